// File: rtl/onchip_mem_pixel_reader.sv
// onchip_mem_pixel_reader
// Avalon-MM read master that streams one frame out of the 1024x32 on-chip
// frame memory and unpacks each word, LSB pixel first, onto an Avalon-ST
// source feeding the VGA pixel pipeline. Software pulses start; the block
// reads FRAME_WORDS words from base_addr (wrapping at 1023), emits
// FRAME_WORDS*PPW pixels with sop/eop markers and pulses done at the end.
module onchip_mem_pixel_reader #(
  parameter int FRAME_WORDS = 1024,
  parameter int PIX_W       = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [9:0]       base_addr,
  output logic             busy,
  output logic             done,
  output logic [9:0]       mem_address,
  output logic             mem_chipselect,
  output logic             mem_write,
  output logic [3:0]       mem_byteenable,
  output logic             mem_clken,
  input  logic [31:0]      mem_readdata,
  output logic [PIX_W-1:0] st_data,
  output logic             st_valid,
  input  logic             st_ready,
  output logic             st_sop,
  output logic             st_eop
);

  localparam int PPW   = 32 / PIX_W;
  localparam int TOTAL = FRAME_WORDS * PPW;
  localparam int IW    = $clog2(FRAME_WORDS + 1);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int KW    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW    = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [9:0]    base_q,     base_d;
  logic [IW-1:0] issued_q,   issued_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [FW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [KW-1:0] pix_k_q,    pix_k_d;
  logic [CW-1:0] pix_cnt_q,  pix_cnt_d;
  logic          done_q,     done_d;

  logic [31:0]   fifo_mem_q [FIFO_DEPTH];

  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          accept;
  logic          last_in_word;
  logic [31:0]   head;

  // Fixed Avalon-MM side-band: read-only master on an always-clocked port.
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  // A read may only go out if the word it returns is guaranteed a FIFO slot,
  // counting the word already on its way back from the memory.
  assign credit_ok = ({1'b0, fifo_cnt_q} + (FW + 1)'(inflight_q)) < (FW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == S_RUN) && (issued_q < IW'(FRAME_WORDS)) && credit_ok && !abort;

  assign mem_chipselect = issue;
  assign mem_address    = base_q + 10'(issued_q);

  // Memory latency is exactly one cycle, so the in-flight flag marks the
  // cycle in which mem_readdata holds the word; an abort discards it.
  assign push = inflight_q && !abort;

  assign head         = fifo_mem_q[rd_ptr_q];
  assign st_valid     = (fifo_cnt_q != '0);
  assign accept       = st_valid && st_ready;
  assign last_in_word = (pix_k_q == KW'(PPW - 1));
  assign pop          = accept && last_in_word;
  assign st_sop       = st_valid && (pix_cnt_q == '0);
  assign st_eop       = st_valid && (pix_cnt_q == CW'(TOTAL - 1));

  // Pixel lane select from the head word, lowest lane first.
  generate
    if (PPW == 1) begin : g_one_lane
      assign st_data = head;
    end else begin : g_lanes
      logic [PPW-1:0][PIX_W-1:0] lanes;
      assign lanes   = head;
      assign st_data = lanes[pix_k_q];
    end
  endgenerate

  // Next-state: FIFO bookkeeping, unpacker position and frame control FSM.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    issued_d   = issued_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + FW'(push) - FW'(pop);
    pix_k_d    = pix_k_q;
    pix_cnt_d  = pix_cnt_q;
    done_d     = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (accept) begin
      pix_k_d   = last_in_word ? '0 : pix_k_q + 1'b1;
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_RUN;
          base_d    = base_addr;
          issued_d  = '0;
          pix_cnt_d = '0;
          pix_k_d   = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == IW'(FRAME_WORDS - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // All reads are out; only the unpacker is still working.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The eop handshake finishes the frame from whichever busy state we are in.
    if (busy && accept && st_eop) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end

    // Abort overrides everything: flush the buffer and drop any read in flight.
    if (busy && abort) begin
      state_d    = S_IDLE;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      pix_k_d    = '0;
      done_d     = 1'b0;
    end
  end

  // Control and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      pix_k_q    <= '0;
      pix_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      pix_k_q    <= pix_k_d;
      pix_cnt_q  <= pix_cnt_d;
      done_q     <= done_d;
    end
  end

  // Word buffer storage; contents are only meaningful under fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_onchip_mem_pixel_reader.sv
// Bench for onchip_mem_pixel_reader: a 4-word 8-bit-pixel instance driven by
// a table of frame vectors plus abort/reset sequences, and a 1-word 32-bit
// pixel instance for the single-pixel sop+eop case.
module tb_onchip_mem_pixel_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  // instance A: FRAME_WORDS=4, PIX_W=8
  logic        start_a, abort_a, busy_a, done_a, cs_a, wr_a, ck_a, valid_a, ready_a, sop_a, eop_a;
  logic [9:0]  base_a, addr_a;
  logic [3:0]  be_a;
  logic [31:0] rdata_a;
  logic [7:0]  data_a;
  // instance B: FRAME_WORDS=1, PIX_W=32
  logic        start_b, abort_b, busy_b, done_b, cs_b, wr_b, ck_b, valid_b, ready_b, sop_b, eop_b;
  logic [9:0]  base_b, addr_b;
  logic [3:0]  be_b;
  logic [31:0] rdata_b;
  logic [31:0] data_b;

  onchip_mem_pixel_reader #(.FRAME_WORDS(4), .PIX_W(8), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .mem_address(addr_a), .mem_chipselect(cs_a),
    .mem_write(wr_a), .mem_byteenable(be_a), .mem_clken(ck_a), .mem_readdata(rdata_a),
    .st_data(data_a), .st_valid(valid_a), .st_ready(ready_a), .st_sop(sop_a), .st_eop(eop_a)
  );

  onchip_mem_pixel_reader #(.FRAME_WORDS(1), .PIX_W(32), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .mem_address(addr_b), .mem_chipselect(cs_b),
    .mem_write(wr_b), .mem_byteenable(be_b), .mem_clken(ck_b), .mem_readdata(rdata_b),
    .st_data(data_b), .st_valid(valid_b), .st_ready(ready_b), .st_sop(sop_b), .st_eop(eop_b)
  );

  // Memory image: word a holds bytes 4a..4a+3 (mod 256), LSB first.
  function automatic logic [31:0] word_of(input logic [9:0] a);
    logic [7:0] b;
    b = {a[5:0], 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // One-cycle read latency memory models
  always @(posedge clk) if (cs_a) rdata_a <= word_of(addr_a);
  always @(posedge clk) if (cs_b) rdata_b <= word_of(addr_b);

  // Sink ready: held high, or about 30% high in backpressure mode
  logic rdy_mode = 1'b0;
  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_a = rdy_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor for instance A
  int          cyc = 0, iss_f = 0, acc_f = 0, max_occ = 0;
  int          busy_rise = 0, first_cs = -1, first_valid = -1;
  int          eop_cyc = 0, done_cyc = 0, done_n = 0, stall_bad = 0;
  logic        busy_prev = 1'b0, prev_stall = 1'b0;
  logic [9:0]  prev_pix = '0;
  logic [9:0]  addr_q[$];
  logic [9:0]  pix_q[$];

  always @(negedge clk) begin
    int occ;
    cyc = cyc + 1;
    if (!busy_a) begin
      iss_f = 0;
      acc_f = 0;
    end
    if (busy_a && !busy_prev) begin
      busy_rise = cyc; max_occ = 0; first_cs = -1; first_valid = -1;
    end
    if (cs_a) begin
      addr_q.push_back(addr_a);
      if (first_cs < 0) first_cs = cyc;
      occ = iss_f + 1 - acc_f / 4;
      if (occ > max_occ) max_occ = occ;
      iss_f = iss_f + 1;
    end
    if (valid_a && first_valid < 0) first_valid = cyc;
    if (prev_stall && reset_n && busy_a && (!valid_a || {sop_a, eop_a, data_a} != prev_pix))
      stall_bad = stall_bad + 1;
    prev_stall = valid_a && !ready_a;
    prev_pix   = {sop_a, eop_a, data_a};
    if (valid_a && ready_a) begin
      pix_q.push_back({sop_a, eop_a, data_a});
      acc_f = acc_f + 1;
      if (eop_a) eop_cyc = cyc;
    end
    if (done_a) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
    busy_prev = busy_a;
  end

  // Monitor for instance B
  int         csb_n = 0;
  logic [9:0] lastaddr_b = '0;
  always @(negedge clk) begin
    if (cs_b) begin
      csb_n      = csb_n + 1;
      lastaddr_b = addr_b;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0]       base;
    logic [3:0][9:0]  exp_addr;
    logic             bp;
    logic             xs;
  } vec_t;

  vec_t vecs [4];

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic run_frame(input int i);
    vec_t        v;
    int          p0, a0, d0, s0, k;
    logic [31:0] w;
    logic [9:0]  expv;
    v  = vecs[i];
    p0 = pix_q.size(); a0 = addr_q.size(); d0 = done_n; s0 = stall_bad;
    rdy_mode = v.bp;
    base_a   = v.base;
    pulse_start_a();
    chk($sformatf("v%0d busy_after_start", i), busy_a, 1);
    if (v.xs) begin
      repeat (3) @(posedge clk);
      #1 base_a = 10'd7; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
    end
    k = 0;
    while (done_n == d0 && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    chk($sformatf("v%0d done_seen", i), done_n != d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d read_count", i), addr_q.size() - a0, 4);
    for (int j = 0; j < 4; j++)
      if (a0 + j < addr_q.size())
        chk($sformatf("v%0d addr%0d", i, j), addr_q[a0 + j], v.exp_addr[j]);
    chk($sformatf("v%0d pixel_count", i), pix_q.size() - p0, 16);
    for (int j = 0; j < 16; j++) begin
      w    = word_of(v.exp_addr[j / 4]);
      expv = {(j == 0), (j == 15), w[(j % 4) * 8 +: 8]};
      if (p0 + j < pix_q.size())
        chk($sformatf("v%0d pix%0d {sop,eop,data}", i, j), pix_q[p0 + j], expv);
    end
    chk($sformatf("v%0d done_pulses", i), done_n - d0, 1);
    chk($sformatf("v%0d done_after_eop", i), done_cyc - eop_cyc, 1);
    chk($sformatf("v%0d stall_stable", i), stall_bad - s0, 0);
    chk($sformatf("v%0d occ_le_depth", i), max_occ <= 4, 1);
    if (v.bp) chk($sformatf("v%0d occ_fills", i), max_occ, 4);
    if (!v.bp && !v.xs) begin
      chk($sformatf("v%0d first_read_lat", i), first_cs - busy_rise, 0);
      chk($sformatf("v%0d first_valid_lat", i), first_valid - busy_rise, 2);
      chk($sformatf("v%0d one_pix_per_cycle", i), eop_cyc - first_valid, 15);
    end
    chk($sformatf("v%0d idle_after", i), busy_a, 0);
  endtask

  initial begin
    int k, d0, p0, p1, a1, c0;
    vecs[0] = '{base: 10'd0,    exp_addr: {10'd3, 10'd2, 10'd1, 10'd0},          bp: 1'b0, xs: 1'b0};
    vecs[1] = '{base: 10'd1022, exp_addr: {10'd1, 10'd0, 10'd1023, 10'd1022},    bp: 1'b0, xs: 1'b0};
    vecs[2] = '{base: 10'd0,    exp_addr: {10'd3, 10'd2, 10'd1, 10'd0},          bp: 1'b1, xs: 1'b0};
    vecs[3] = '{base: 10'd1020, exp_addr: {10'd1023, 10'd1022, 10'd1021, 10'd1020}, bp: 1'b0, xs: 1'b1};

    reset_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; base_a = '0;
    start_b = 1'b0; abort_b = 1'b0; base_b = '0; ready_b = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy",     busy_a,  0);
    chk("rst done",     done_a,  0);
    chk("rst cs",       cs_a,    0);
    chk("rst valid",    valid_a, 0);
    chk("rst sop_eop",  {sop_a, eop_a}, 0);
    chk("rst addr",     addr_a,  0);
    chk("tie write",    wr_a,    0);
    chk("tie be",       be_a,    4'hF);
    chk("tie clken",    ck_a,    1);
    chk("rst b busy_valid", {busy_b, valid_b}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames
    for (int i = 0; i < 4; i++) run_frame(i);

    // abort together with start while idle: abort wins
    @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
    chk("abort_wins_busy", busy_a, 0);
    chk("abort_wins_cs",   cs_a,   0);

    // Abort after 5 pixels
    rdy_mode = 1'b0; base_a = 10'd0; d0 = done_n; p0 = pix_q.size();
    pulse_start_a();
    k = 0;
    while (pix_q.size() - p0 < 5 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("abort reached5", (pix_q.size() - p0) >= 5, 1);
    abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    chk("abort busy",  busy_a,  0);
    chk("abort valid", valid_a, 0);
    chk("abort cs",    cs_a,    0);
    p1 = pix_q.size(); a1 = addr_q.size();
    repeat (10) @(posedge clk);
    #1;
    chk("abort no_done",   done_n - d0,         0);
    chk("abort no_pixels", pix_q.size() - p1,   0);
    chk("abort no_reads",  addr_q.size() - a1,  0);
    run_frame(0);

    // Async reset mid-frame
    rdy_mode = 1'b0; base_a = 10'd1022; p0 = pix_q.size();
    pulse_start_a();
    k = 0;
    while (pix_q.size() - p0 < 3 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("areset reached3", (pix_q.size() - p0) >= 3, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset busy",  busy_a,  0);
    chk("areset cs",    cs_a,    0);
    chk("areset valid", valid_a, 0);
    chk("areset sop_eop_done", {sop_a, eop_a, done_a}, 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    run_frame(1);

    // Single-word 32-bit pixel frame: sop and eop on one pixel
    c0 = csb_n;
    @(posedge clk); #1 base_b = 10'd5; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("b busy", busy_b, 1);
    k = 0;
    while (!valid_b && k < 10) begin
      @(posedge clk); #1; k++;
    end
    chk("b first_valid_lat", k, 2);
    chk("b data",    data_b, 32'h17161514);
    chk("b sop_eop", {sop_b, eop_b}, 2'b11);
    chk("b addr",    lastaddr_b, 5);
    @(posedge clk); #1;
    chk("b done",       done_b,  1);
    chk("b busy_clear", busy_b,  0);
    chk("b valid_clear", valid_b, 0);
    @(posedge clk); #1;
    chk("b done_pulse", done_b, 0);
    chk("b reads", csb_n - c0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
